pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
Parametrised program-counter sequencer for the MIPS datapath fetch stage; replaces the fixed 32-bit PC register plus external +4 adder.
- Selects the next PC from sequential increment, branch, jump, return or exception vector, with stall support.
- Holds a small circular return-address stack (RAS) for call/return.
- Emits a one-cycle redirect pulse so later stages can flush.

Parameters:
WIDTH, 32, PC width in bits
RESET_VECTOR, 0, PC value loaded on reset
STEP, 4, sequential increment in bytes (power of two)
EXC_VECTOR, 32'h0000_0180, PC value loaded on exception
RAS_DEPTH, 4, return-address stack entries (power of two, >=2)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
stall  input  1  hold PC and RAS; all redirect requests except exception ignored
branch_taken  input  1  redirect to branch_target
branch_target  input  WIDTH  branch destination
jump  input  1  redirect to jump_target
jump_target  input  WIDTH  jump destination
call  input  1  with jump: push pc_out+STEP onto RAS
ret  input  1  pop RAS and redirect to popped address
exception  input  1  redirect to EXC_VECTOR
pc_out  output  WIDTH  current PC (registered)
pc_next  output  WIDTH  combinational value pc_out takes at next edge (ignores rst)
redirect_valid  output  1  registered; high one cycle after any non-sequential update
ras_count  output  $clog2(RAS_DEPTH)+1  valid RAS entries
ras_overflow  output  1  sticky; set when a push overwrote the oldest entry
ras_underflow  output  1  sticky; set when ret seen with RAS empty
misalign  output  1  registered misaligned-target flag (see Optional Feature)

Behaviour:
- Reset (rst=1 at edge): pc_out=RESET_VECTOR; redirect_valid=0; ras_count=0; ras_overflow=0; ras_underflow=0; misalign=0; RAS contents don't-care. rst overrides every other input.
- Next-PC priority, highest first: exception -> EXC_VECTOR; stall -> hold; ret -> RAS top; jump -> jump_target; branch_taken -> branch_target; else pc_out+STEP.
- Exception beats stall. Exception leaves the RAS unchanged.
- Sequential increment wraps modulo 2^WIDTH, e.g. WIDTH=32: 32'hFFFF_FFFC+4 -> 0. No flag.
- Latency: a request sampled at edge N appears on pc_out after edge N. redirect_valid is high during the following cycle only.
- redirect_valid=1 after an exception, ret (including underflow), jump or branch update; 0 after sequential update, stall or reset.
- Call: pushes pc_out+STEP only when jump=1, stall=0 and no exception/ret that cycle. call without jump is ignored.
- Push on full RAS (count==RAS_DEPTH): overwrite oldest entry; count stays RAS_DEPTH; ras_overflow<=1.
- Ret with count>0: pop; pc_out<=popped entry; count-1.
- Ret with count==0: ras_underflow<=1; pc_out<=pc_out+STEP; redirect_valid still pulses.
- ret with jump/call in the same cycle: ret wins; no push.
- Stall: pc_out, RAS, count and flags hold; redirect_valid<=0. Requests are dropped, not queued; the upstream stage re-presents them.
- Sticky flags clear only on rst.
- pc_next follows the same priority combinationally, so fetch can index memory one cycle early.

Optional Feature:
Macro PC_ALIGN_CHECK_EN.
- Defined: a jump, branch or ret target with any of the low log2(STEP) bits set is not taken. Instead pc_out<=EXC_VECTOR, misalign<=1 for one cycle, redirect_valid<=1, and no push/pop occurs.
- Undefined: targets are loaded unmodified, misalign is tied 0, and no check logic is generated.

Test Plan:
- Reset then 3 free-run cycles, defaults -> pc_out 0, 4, 8, 12; redirect_valid 0 throughout.
- At pc_out=8, branch_taken=1, target=0x40 -> next pc_out 0x40, redirect_valid 1 for one cycle, then 0x44.
- At pc_out=0x10, jump+call to 0x100, then ret at 0x104 -> pc_out 0x100, ras_count 1, then pc_out 0x14, ras_count 0.
- 5 nested calls (RAS_DEPTH=4) then 5 rets -> ras_overflow=1. First 4 rets return newest-first. Fifth ret sets ras_underflow=1 and gives sequential PC.
- stall=1 with branch_taken=1 for 2 cycles, then exception with stall=1 -> pc_out holds, then becomes 0x180.
- PC_ALIGN_CHECK_EN defined, jump to 0x102 -> pc_out 0x180, misalign=1 one cycle. With macro undefined -> pc_out 0x102.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with branch/jump/return/exception redirect, circular RAS and redirect pulse.
// Define PC_ALIGN_CHECK_EN to trap misaligned jump/branch/ret targets to EXC_VECTOR.
module pc_sequencer #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               STEP         = 4,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = 'h0000_0180,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         branch_taken,
    input  logic [WIDTH-1:0]             branch_target,
    input  logic                         jump,
    input  logic [WIDTH-1:0]             jump_target,
    input  logic                         call,
    input  logic                         ret,
    input  logic                         exception,
    output logic [WIDTH-1:0]             pc_out,
    output logic [WIDTH-1:0]             pc_next,
    output logic                         redirect_valid,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         ras_underflow,
    output logic                         misalign
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]    ras_top;
    logic [PW-1:0]    top_idx;
    logic [WIDTH-1:0] pc_seq;
    logic [WIDTH-1:0] ras_data;
    logic [WIDTH-1:0] target;
    logic             take_target;
    logic             redir;
    logic             do_push;
    logic             do_pop;
    logic             underflow_set;
    logic             mis;

    // ras_top is the next free slot; when full it also points at the oldest entry
    assign pc_seq   = pc_out + STEP_V;
    assign top_idx  = ras_top - PW'(1);
    assign ras_data = ras_mem[top_idx];

    always_comb begin
        pc_next       = pc_seq;
        target        = pc_seq;
        take_target   = 1'b0;
        redir         = 1'b0;
        do_push       = 1'b0;
        do_pop        = 1'b0;
        underflow_set = 1'b0;
        mis           = 1'b0;
        if (exception) begin
            pc_next = EXC_VECTOR;
            redir   = 1'b1;
        end else if (stall) begin
            pc_next = pc_out;
        end else begin
            if (ret) begin
                redir = 1'b1;
                if (ras_count == '0) begin
                    underflow_set = 1'b1;
                end else begin
                    target      = ras_data;
                    take_target = 1'b1;
                    do_pop      = 1'b1;
                end
            end else if (jump) begin
                target      = jump_target;
                take_target = 1'b1;
                redir       = 1'b1;
                do_push     = call;
            end else if (branch_taken) begin
                target      = branch_target;
                take_target = 1'b1;
                redir       = 1'b1;
            end
            if (take_target) begin
                pc_next = target;
            end
`ifdef PC_ALIGN_CHECK_EN
            if (take_target && ((target & WIDTH'(STEP - 1)) != '0)) begin
                pc_next = EXC_VECTOR;
                mis     = 1'b1;
                do_push = 1'b0;
                do_pop  = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_out         <= RESET_VECTOR;
            redirect_valid <= 1'b0;
            ras_count      <= '0;
            ras_top        <= '0;
            ras_overflow   <= 1'b0;
            ras_underflow  <= 1'b0;
        end else begin
            pc_out         <= pc_next;
            redirect_valid <= redir;
            if (do_push) begin
                ras_top <= ras_top + PW'(1);
                if (ras_count == CW'(RAS_DEPTH)) begin
                    ras_overflow <= 1'b1;
                end else begin
                    ras_count <= ras_count + CW'(1);
                end
            end else if (do_pop) begin
                ras_top   <= top_idx;
                ras_count <= ras_count - CW'(1);
            end
            if (underflow_set) begin
                ras_underflow <= 1'b1;
            end
        end
    end

    // Stack storage carries no reset; validity is tracked by ras_count
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            ras_mem[ras_top] <= pc_seq;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign <= 1'b0;
        end else begin
            misalign <= mis;
        end
    end
`else
    assign misalign = 1'b0;
`endif

endmodule
